// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, muxes the loader onto the memory write port in IDLE
// and fills the IF/ID register in RUN/SQUASH. Optional HAZARD_NOP_EN adds automatic bubbles.
module fetch_sequencer #(
    parameter int unsigned       ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              run,
    input  logic              halt,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic [31:0]       imem_pc,
    input  logic [31:0]       imem_ir,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_ir,
    output logic              if_valid,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_SQUASH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       if_pc_q, if_pc_d;
    logic [31:0]       if_ir_q, if_ir_d;
    logic              if_valid_q, if_valid_d;
`ifdef HAZARD_NOP_EN
    logic              bubble_q, bubble_d;
`endif

    logic unused_redirect_hi;
    assign unused_redirect_hi = ^redirect_pc[31:ADDR_W];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_ir_d    = if_ir_q;
        if_valid_d = if_valid_q;
        load_ready = 1'b0;
        imem_we    = 1'b0;
        imem_waddr = load_addr;
        imem_wdata = load_data;
`ifdef HAZARD_NOP_EN
        bubble_d   = bubble_q;
`endif
        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
                imem_we    = load_valid;
                if_ir_d    = '0;
                if_valid_d = 1'b0;
                // A pending loader write takes the cycle; run is dropped, not queued.
                if (run && !load_valid) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end
            ST_RUN, ST_SQUASH: begin
                if (halt) begin
                    state_d    = ST_IDLE;
                    if_ir_d    = '0;
                    if_valid_d = 1'b0;
`ifdef HAZARD_NOP_EN
                    bubble_d   = 1'b0;
`endif
                end else if (redirect_valid) begin
                    state_d    = ST_SQUASH;
                    pc_d       = redirect_pc[ADDR_W-1:0];
                    if_ir_d    = '0;
                    if_valid_d = 1'b0;
`ifdef HAZARD_NOP_EN
                    bubble_d   = 1'b0;
`endif
                end else if (!stall) begin
                    state_d = ST_RUN;
`ifdef HAZARD_NOP_EN
                    if (bubble_q) begin
                        if_ir_d    = '0;
                        if_valid_d = 1'b0;
                        bubble_d   = 1'b0;
                    end else begin
                        if_ir_d    = imem_ir;
                        if_pc_d    = imem_pc;
                        if_valid_d = 1'b1;
                        pc_d       = pc_q + 1'b1;
                        bubble_d   = |imem_ir[31:25];
                    end
`else
                    if_ir_d    = imem_ir;
                    if_pc_d    = imem_pc;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            if_pc_q    <= '0;
            if_ir_q    <= '0;
            if_valid_q <= 1'b0;
`ifdef HAZARD_NOP_EN
            bubble_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_ir_q    <= if_ir_d;
            if_valid_q <= if_valid_d;
`ifdef HAZARD_NOP_EN
            bubble_q   <= bubble_d;
`endif
        end
    end

    assign imem_pc  = {{(32-ADDR_W){1'b0}}, pc_q};
    assign if_pc    = if_pc_q;
    assign if_ir    = if_ir_q;
    assign if_valid = if_valid_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
